cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Common-data-bus arbiter. Each functional unit (0=ALU, 1=LS, 2=BR) pushes
//   results into its own small FIFO. One FIFO head per cycle is granted
//   round-robin and broadcast on the registered out_cdb_* bus.
//
// Ports
//   in_clk, in_rst         clock, synchronous active-high reset
//   in_fu_valid/ready      per-requester handshake (push on valid & ready)
//   in_fu_value/rob_index/set_nzcv/nzcv
//                          per-requester payload, flattened (requester i at slice i)
//   in_flush               drops every buffered result; no broadcast next cycle
//   in_stall               ROB back-pressure; blocks grants and pops
//   out_cdb_*              registered broadcast and the id of its producer
module cdb_arbiter #(
  parameter int NUM_FU       = 3,
  parameter int DEPTH        = 2,
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 5,
  localparam int FU_ID_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                             in_clk,
  input  logic                             in_rst,
  input  logic [NUM_FU-1:0]                in_fu_valid,
  input  logic [NUM_FU*GPR_SIZE-1:0]       in_fu_value,
  input  logic [NUM_FU*ROB_IDX_SIZE-1:0]   in_fu_rob_index,
  input  logic [NUM_FU-1:0]                in_fu_set_nzcv,
  input  logic [NUM_FU*4-1:0]              in_fu_nzcv,
  output logic [NUM_FU-1:0]                out_fu_ready,
  input  logic                             in_flush,
  input  logic                             in_stall,
  output logic                             out_cdb_valid,
  output logic [GPR_SIZE-1:0]              out_cdb_value,
  output logic [ROB_IDX_SIZE-1:0]          out_cdb_rob_index,
  output logic                             out_cdb_set_nzcv,
  output logic [3:0]                       out_cdb_nzcv,
  output logic [FU_ID_W-1:0]               out_cdb_fu_id
);

  localparam int PW    = GPR_SIZE + ROB_IDX_SIZE + 1 + 4;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_FU-1:0]      nonempty;
  logic [NUM_FU*PW-1:0]   head_flat;
  logic                   grant_found;
  logic                   grant_valid;
  logic [FU_ID_W-1:0]     grant_idx;
  logic [PW-1:0]          grant_payload;
  logic [FU_ID_W-1:0]     rr_ptr_reg;

  logic                   cdb_valid_reg;
  logic [GPR_SIZE-1:0]    cdb_value_reg;
  logic [ROB_IDX_SIZE-1:0] cdb_rob_reg;
  logic                   cdb_set_reg;
  logic [3:0]             cdb_nzcv_reg;
  logic [FU_ID_W-1:0]     cdb_fu_reg;

  // Per-requester result FIFOs
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fifo
    logic [PW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push;
    logic             pop;

    // No pop bypass: a full FIFO stays not-ready even in a cycle it is popped.
    assign out_fu_ready[gi] = (count_reg < CNT_W'(DEPTH)) && !in_flush && !in_rst;
    assign push             = in_fu_valid[gi] && out_fu_ready[gi];
    assign pop              = grant_valid && (grant_idx == FU_ID_W'(gi));
    assign nonempty[gi]     = (count_reg != '0);
    assign head_flat[gi*PW +: PW] = mem[head_reg];

    always_ff @(posedge in_clk) begin
      if (in_rst || in_flush) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push)
          tail_reg <= (tail_reg == PTR_W'(DEPTH - 1)) ? '0 : tail_reg + 1'b1;
        if (pop)
          head_reg <= (head_reg == PTR_W'(DEPTH - 1)) ? '0 : head_reg + 1'b1;
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end

    // Payload storage carries no reset; count/pointers define what is valid.
    always_ff @(posedge in_clk) begin
      if (push)
        mem[tail_reg] <= {in_fu_value[gi*GPR_SIZE +: GPR_SIZE],
                          in_fu_rob_index[gi*ROB_IDX_SIZE +: ROB_IDX_SIZE],
                          in_fu_set_nzcv[gi],
                          in_fu_nzcv[gi*4 +: 4]};
    end
  end

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_found   = 1'b0;
    grant_idx     = '0;
    grant_payload = '0;
    for (int k = 1; k <= NUM_FU; k++) begin
      if (!grant_found && nonempty[(int'(rr_ptr_reg) + k) % NUM_FU]) begin
        grant_found   = 1'b1;
        grant_idx     = FU_ID_W'((int'(rr_ptr_reg) + k) % NUM_FU);
        grant_payload = head_flat[((int'(rr_ptr_reg) + k) % NUM_FU)*PW +: PW];
      end
    end
  end

  // Flush and reset win over a grant through the register priority below;
  // FIFO pops are cancelled by the same priority inside each FIFO.
  assign grant_valid = grant_found && !in_stall;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rr_ptr_reg    <= FU_ID_W'(NUM_FU - 1);
      cdb_valid_reg <= 1'b0;
      cdb_value_reg <= '0;
      cdb_rob_reg   <= '0;
      cdb_set_reg   <= 1'b0;
      cdb_nzcv_reg  <= '0;
      cdb_fu_reg    <= '0;
    end else if (in_flush) begin
      cdb_valid_reg <= 1'b0;
    end else if (grant_valid) begin
      cdb_valid_reg <= 1'b1;
      {cdb_value_reg, cdb_rob_reg, cdb_set_reg, cdb_nzcv_reg} <= grant_payload;
      cdb_fu_reg    <= grant_idx;
      rr_ptr_reg    <= grant_idx;
    end else begin
      cdb_valid_reg <= 1'b0;
    end
  end

  assign out_cdb_valid     = cdb_valid_reg;
  assign out_cdb_value     = cdb_value_reg;
  assign out_cdb_rob_index = cdb_rob_reg;
  assign out_cdb_set_nzcv  = cdb_set_reg;
  assign out_cdb_nzcv      = cdb_nzcv_reg;
  assign out_cdb_fu_id     = cdb_fu_reg;

endmodule
